// File: rtl/processor_core.sv
// processor_core: three-stage 32-bit load/store pipeline (IF/ID, EX/MEM, WB).
// IM is loaded through im_WE/im_DATA; file strobes are ignored.
module processor_core #(
    parameter IM_FILE = "instructions.mem",
    parameter DM_FILE = "data.mem",
    parameter int MEM_DEPTH = 256
) (
    input logic        CLK,
    input logic        pc_RESET,
    input logic        reg_ifid_exmem_RESET,
    input logic        reg_exmem_wb_RESET,
    input logic        rb_RESET,
    input logic        tf_RESET,
    input logic        im_RESET,
    input logic        dm_RESET,
    input logic        reg_ifid_exmem_ENABLE,
    input logic        reg_exmem_wb_ENABLE,
    input logic        im_WE,
    input logic [31:0] im_DATA,
    input logic        im_read_file,
    input logic        im_write_file,
    input logic        dm_read_file,
    input logic        dm_write_file
);
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
        OP_LDI, OP_LOAD, OP_STORE, OP_JMP, OP_JZ, OP_JN, OP_JC, OP_HALT
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] imm;
        logic [7:0]  pc;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vd;
    } id_ex_t;

    typedef struct packed {
        op_t         op;
        logic [3:0]  rd;
        logic [31:0] res;
    } ex_wb_t;

    logic [31:0] im [MEM_DEPTH];
    logic [31:0] dm [MEM_DEPTH];
    logic [31:0] rf [16];
    logic [7:0]  pc;
    logic [7:0]  im_ptr;
    logic [3:0]  tf;
    id_ex_t      id_ex;
    id_ex_t      id_next;
    ex_wb_t      ex_wb;
    ex_wb_t      ex_next;

    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] instr;
    logic [31:0] a, b, d, sext, alu;
    logic [32:0] sum;
    logic [3:0]  tf_next;
    logic [7:0]  target, addr;
    logic        taken, ex_taken, ex_valid, dm_we, fwd, cf, vf;

    assign fwd     = (ex_wb.op >= OP_ADD) && (ex_wb.op <= OP_LOAD);
    assign wb_we   = fwd && reg_exmem_wb_ENABLE && !reg_exmem_wb_RESET
                     && !rb_RESET;
    assign wb_rd   = ex_wb.rd;
    assign wb_data = ex_wb.res;
    assign instr   = im[pc];

    always_comb begin
        id_next     = '0;
        id_next.op  = op_t'(instr[31:28]);
        id_next.rd  = instr[27:24];
        id_next.ra  = instr[23:20];
        id_next.rb  = instr[19:16];
        id_next.imm = instr[15:0];
        id_next.pc  = pc;
        id_next.va  = (wb_we && wb_rd == instr[23:20]) ? wb_data
                                                       : rf[instr[23:20]];
        id_next.vb  = (wb_we && wb_rd == instr[19:16]) ? wb_data
                                                       : rf[instr[19:16]];
        id_next.vd  = (wb_we && wb_rd == instr[27:24]) ? wb_data
                                                       : rf[instr[27:24]];
    end

    assign a    = (fwd && ex_wb.rd == id_ex.ra) ? ex_wb.res : id_ex.va;
    assign b    = (fwd && ex_wb.rd == id_ex.rb) ? ex_wb.res : id_ex.vb;
    assign d    = (fwd && ex_wb.rd == id_ex.rd) ? ex_wb.res : id_ex.vd;
    assign sext = {{16{id_ex.imm[15]}}, id_ex.imm};
    assign addr = a[7:0] + id_ex.imm[7:0];

    always_comb begin
        alu     = '0;
        sum     = '0;
        cf      = 1'b0;
        vf      = 1'b0;
        taken   = 1'b0;
        target  = id_ex.imm[7:0];
        tf_next = tf;
        unique case (id_ex.op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                alu = sum[31:0];
                cf  = sum[32];
                vf  = (a[31] == b[31]) && (alu[31] != a[31]);
            end
            OP_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                alu = sum[31:0];
                cf  = sum[32];
                vf  = (a[31] != b[31]) && (alu[31] != a[31]);
            end
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SHL:  alu = a << b[4:0];
            OP_SHR:  alu = a >> b[4:0];
            OP_LDI:  alu = sext;
            OP_LOAD: alu = dm[addr];
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = tf[3];
            OP_JN:   taken = tf[2];
            OP_JC:   taken = tf[1];
            OP_HALT: begin
                taken  = 1'b1;
                target = id_ex.pc;
            end
            default: ;
        endcase
        if (id_ex.op >= OP_ADD && id_ex.op <= OP_SHR)
            tf_next = {alu == 32'd0, alu[31], cf, vf};
    end

    assign ex_valid   = !reg_ifid_exmem_RESET;
    assign ex_taken   = taken && ex_valid;
    assign dm_we      = (id_ex.op == OP_STORE) && ex_valid
                        && reg_exmem_wb_ENABLE;
    assign ex_next.op  = ex_valid ? id_ex.op : OP_NOP;
    assign ex_next.rd  = id_ex.rd;
    assign ex_next.res = alu;

    always_ff @(posedge CLK) begin
        if (pc_RESET)
            pc <= '0;
        else if (reg_ifid_exmem_ENABLE)
            pc <= ex_taken ? target : pc + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (reg_ifid_exmem_RESET)
            id_ex <= '0;
        else if (reg_ifid_exmem_ENABLE)
            id_ex <= ex_taken ? '0 : id_next;
    end

    always_ff @(posedge CLK) begin
        if (reg_exmem_wb_RESET)
            ex_wb <= '0;
        else if (reg_exmem_wb_ENABLE)
            ex_wb <= ex_next;
    end

    always_ff @(posedge CLK) begin
        if (tf_RESET)
            tf <= '0;
        else if (reg_exmem_wb_ENABLE && ex_valid)
            tf <= tf_next;
    end

    always_ff @(posedge CLK) begin
        if (rb_RESET) begin
            for (int i = 0; i < 16; i++)
                rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (dm_RESET) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                dm[i] <= '0;
        end else if (dm_we) begin
            dm[addr] <= d;
        end
    end

    always_ff @(posedge CLK) begin
        if (im_RESET) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                im[i] <= '0;
            im_ptr <= '0;
        end else if (im_WE) begin
            im[im_ptr] <= im_DATA;
            im_ptr     <= im_ptr + 8'd1;
        end
    end

    localparam int unused_files = $bits(IM_FILE) + $bits(DM_FILE);
    logic unused_strobes;
    assign unused_strobes = &{1'b0, im_read_file, im_write_file,
                              dm_read_file, dm_write_file};

endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: scoreboard of expected register writes plus
// end-state checks on DM, RB, TF and PC.
`timescale 1ns/1ps
module tb_processor_core;
    logic        clk = 1'b0;
    logic        pc_RESET, reg_ifid_exmem_RESET, reg_exmem_wb_RESET;
    logic        rb_RESET, tf_RESET, im_RESET, dm_RESET;
    logic        reg_ifid_exmem_ENABLE, reg_exmem_wb_ENABLE;
    logic        im_WE;
    logic [31:0] im_DATA;
    logic        im_read_file, im_write_file, dm_read_file, dm_write_file;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] val;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] prog[$];

    always #5 clk = ~clk;

    processor_core dut (
        .CLK(clk),
        .pc_RESET(pc_RESET),
        .reg_ifid_exmem_RESET(reg_ifid_exmem_RESET),
        .reg_exmem_wb_RESET(reg_exmem_wb_RESET),
        .rb_RESET(rb_RESET),
        .tf_RESET(tf_RESET),
        .im_RESET(im_RESET),
        .dm_RESET(dm_RESET),
        .reg_ifid_exmem_ENABLE(reg_ifid_exmem_ENABLE),
        .reg_exmem_wb_ENABLE(reg_exmem_wb_ENABLE),
        .im_WE(im_WE),
        .im_DATA(im_DATA),
        .im_read_file(im_read_file),
        .im_write_file(im_write_file),
        .dm_read_file(dm_read_file),
        .dm_write_file(dm_write_file)
    );

    // Every register-bank write must match the next expected one in order.
    always @(negedge clk) begin
        if (dut.wb_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got r%0d<=%h, required none",
                         dut.wb_rd, dut.wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (dut.wb_rd !== mon_e.rd || dut.wb_data !== mon_e.val) begin
                    failures++;
                    $display("FAIL wb_write: got r%0d<=%h, required r%0d<=%h",
                             dut.wb_rd, dut.wb_data, mon_e.rd, mon_e.val);
                end
            end
        end
    end

    function automatic logic [31:0] enc(int op, int rd, int ra, int rb,
                                        int imm);
        return {op[3:0], rd[3:0], ra[3:0], rb[3:0], imm[15:0]};
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(int rd, logic [31:0] val);
        wr_t e;
        e.rd  = rd[3:0];
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic load_prog();
        {pc_RESET, reg_ifid_exmem_RESET, reg_exmem_wb_RESET} = 3'b111;
        {rb_RESET, tf_RESET, im_RESET, dm_RESET} = 4'b1111;
        tick(1);
        {rb_RESET, tf_RESET, im_RESET, dm_RESET} = 4'b0000;
        foreach (prog[i]) begin
            im_WE   = 1'b1;
            im_DATA = prog[i];
            tick(1);
        end
        im_WE = 1'b0;
        {pc_RESET, reg_ifid_exmem_RESET, reg_exmem_wb_RESET} = 3'b000;
    endtask

    task automatic check_drained(string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending: got %0d writes missing, required 0",
                     name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        {pc_RESET, reg_ifid_exmem_RESET, reg_exmem_wb_RESET} = 3'b111;
        {rb_RESET, tf_RESET, im_RESET, dm_RESET} = 4'b1111;
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        tick(1);
        checks++;
        if (dut.pc !== 8'd0 || dut.tf !== 4'd0 || dut.im_ptr !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got pc=%h tf=%b ptr=%h, required 0",
                     dut.pc, dut.tf, dut.im_ptr);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.rf[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset_rf: got r%0d=%h, required 0",
                         i, dut.rf[i]);
            end
        end
    endtask

    task automatic test_basic();
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 5), enc(8, 2, 0, 0, 7), enc(1, 3, 1, 2, 0),
                enc(10, 3, 0, 0, 4), enc(15, 0, 0, 0, 0)};
        expect_wr(1, 32'd5);
        expect_wr(2, 32'd7);
        expect_wr(3, 32'd12);
        load_prog();
        tick(10);
        checks++;
        if (dut.dm[4] !== 32'd12 || dut.rf[3] !== 32'd12) begin
            failures++;
            $display("FAIL basic_result: got dm4=%h r3=%h, required 12",
                     dut.dm[4], dut.rf[3]);
        end
        checks++;
        if (dut.pc !== 8'd4) begin
            failures++;
            $display("FAIL basic_halt_pc: got %h, required 04", dut.pc);
        end
        check_drained("basic");
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 1), enc(1, 1, 1, 1, 0), enc(1, 1, 1, 1, 0),
                enc(1, 1, 1, 1, 0), enc(15, 0, 0, 0, 0)};
        expect_wr(1, 32'd1);
        expect_wr(1, 32'd2);
        expect_wr(1, 32'd4);
        expect_wr(1, 32'd8);
        load_prog();
        tick(10);
        checks++;
        if (dut.rf[1] !== 32'd8) begin
            failures++;
            $display("FAIL b2b_r1: got %h, required 8", dut.rf[1]);
        end
        check_drained("b2b");
    endtask

    task automatic test_jump();
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 9), enc(2, 4, 1, 1, 0), enc(12, 0, 0, 0, 'h20),
                enc(8, 5, 0, 0, 'h55), enc(8, 7, 0, 0, 'h77)};
        while (prog.size() < 'h20)
            prog.push_back(32'd0);
        prog.push_back(enc(8, 6, 0, 0, 'h66));
        prog.push_back(enc(15, 0, 0, 0, 0));
        expect_wr(1, 32'd9);
        expect_wr(4, 32'd0);
        expect_wr(6, 32'h66);
        load_prog();
        tick(12);
        checks++;
        if (dut.rf[5] !== 32'd0 || dut.rf[7] !== 32'd0) begin
            failures++;
            $display("FAIL jz_squash: got r5=%h r7=%h, required 0",
                     dut.rf[5], dut.rf[7]);
        end
        checks++;
        if (dut.rf[6] !== 32'h66 || dut.tf !== 4'b1000) begin
            failures++;
            $display("FAIL jz_target: got r6=%h tf=%b, required 66 1000",
                     dut.rf[6], dut.tf);
        end
        check_drained("jz");
    endtask

    task automatic test_overflow();
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 'hFFFF), enc(8, 2, 0, 0, 1),
                enc(7, 1, 1, 2, 0), enc(1, 3, 1, 2, 0), enc(15, 0, 0, 0, 0)};
        expect_wr(1, 32'hFFFF_FFFF);
        expect_wr(2, 32'd1);
        expect_wr(1, 32'h7FFF_FFFF);
        expect_wr(3, 32'h8000_0000);
        load_prog();
        tick(10);
        checks++;
        if (dut.rf[3] !== 32'h8000_0000 || dut.tf !== 4'b0101) begin
            failures++;
            $display("FAIL ovf_flags: got r3=%h tf=%b, required 80000000 0101",
                     dut.rf[3], dut.tf);
        end
        check_drained("ovf");
    endtask

    task automatic test_carry_borrow();
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 1), enc(8, 2, 0, 0, 2),
                enc(8, 4, 0, 0, 'hFFFF), enc(2, 3, 1, 2, 0),
                enc(14, 0, 0, 0, 7), enc(8, 7, 0, 0, 'h77),
                enc(8, 7, 0, 0, 'h78), enc(1, 5, 4, 1, 0),
                enc(15, 0, 0, 0, 0)};
        expect_wr(1, 32'd1);
        expect_wr(2, 32'd2);
        expect_wr(4, 32'hFFFF_FFFF);
        expect_wr(3, 32'hFFFF_FFFF);
        expect_wr(5, 32'd0);
        load_prog();
        tick(14);
        checks++;
        if (dut.rf[7] !== 32'd0) begin
            failures++;
            $display("FAIL jc_borrow: got r7=%h, required 0", dut.rf[7]);
        end
        checks++;
        if (dut.tf !== 4'b1010) begin
            failures++;
            $display("FAIL carry_flags: got tf=%b, required 1010", dut.tf);
        end
        check_drained("carry");
    endtask

    task automatic test_freeze();
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 5), enc(8, 2, 0, 0, 7), enc(1, 3, 1, 2, 0),
                enc(10, 3, 0, 0, 4), enc(15, 0, 0, 0, 0)};
        expect_wr(1, 32'd5);
        expect_wr(2, 32'd7);
        expect_wr(3, 32'd12);
        load_prog();
        tick(3);
        reg_ifid_exmem_ENABLE = 1'b0;
        reg_exmem_wb_ENABLE   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if (dut.pc !== 8'd3) begin
                failures++;
                $display("FAIL freeze_pc: got %h, required 03", dut.pc);
            end
        end
        checks++;
        if (dut.rf[2] !== 32'd0 || dut.dm[4] !== 32'd0) begin
            failures++;
            $display("FAIL freeze_writes: got r2=%h dm4=%h, required 0",
                     dut.rf[2], dut.dm[4]);
        end
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        tick(10);
        checks++;
        if (dut.dm[4] !== 32'd12 || dut.rf[3] !== 32'd12) begin
            failures++;
            $display("FAIL freeze_result: got dm4=%h r3=%h, required 12",
                     dut.dm[4], dut.rf[3]);
        end
        check_drained("freeze");
    endtask

    task automatic test_rb_tf_reset();
        logic [31:0] img [256];
        exp_q.delete();
        prog = {enc(8, 1, 0, 0, 5), enc(8, 2, 0, 0, 7), enc(1, 3, 1, 2, 0),
                enc(10, 3, 0, 0, 4), enc(8, 4, 0, 0, 'hFFFF),
                enc(1, 5, 4, 4, 0), enc(10, 5, 3, 0, 'h10),
                enc(15, 0, 0, 0, 0)};
        expect_wr(1, 32'd5);
        expect_wr(2, 32'd7);
        expect_wr(3, 32'd12);
        expect_wr(4, 32'hFFFF_FFFF);
        expect_wr(5, 32'hFFFF_FFFE);
        for (int i = 0; i < 256; i++)
            img[i] = 32'd0;
        img[4]  = 32'd12;
        img[28] = 32'hFFFF_FFFE;
        load_prog();
        tick(14);
        checks++;
        if (dut.tf !== 4'b0110) begin
            failures++;
            $display("FAIL pre_reset_tf: got %b, required 0110", dut.tf);
        end
        {rb_RESET, tf_RESET} = 2'b11;
        tick(1);
        {rb_RESET, tf_RESET} = 2'b00;
        checks++;
        if (dut.tf !== 4'd0) begin
            failures++;
            $display("FAIL tf_reset: got %b, required 0000", dut.tf);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.rf[i] !== 32'd0) begin
                failures++;
                $display("FAIL rb_reset: got r%0d=%h, required 0",
                         i, dut.rf[i]);
            end
        end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (dut.dm[i] !== img[i]) begin
                failures++;
                $display("FAIL dm_image: got dm[%0d]=%h, required %h",
                         i, dut.dm[i], img[i]);
            end
        end
        check_drained("rbtf");
    endtask

    task automatic test_im_priority();
        im_WE   = 1'b1;
        im_DATA = 32'hDEAD_BEEF;
        tick(1);
        im_RESET = 1'b1;
        tick(1);
        im_RESET = 1'b0;
        checks++;
        if (dut.im[0] !== 32'd0 || dut.im_ptr !== 8'd0) begin
            failures++;
            $display("FAIL im_reset_wins: got im0=%h ptr=%h, required 0",
                     dut.im[0], dut.im_ptr);
        end
        im_DATA = 32'h1234_5678;
        tick(1);
        im_WE = 1'b0;
        checks++;
        if (dut.im[0] !== 32'h1234_5678 || dut.im_ptr !== 8'd1) begin
            failures++;
            $display("FAIL im_write: got im0=%h ptr=%h, required 12345678 01",
                     dut.im[0], dut.im_ptr);
        end
    endtask

    initial begin
        {pc_RESET, reg_ifid_exmem_RESET, reg_exmem_wb_RESET} = 3'b111;
        {rb_RESET, tf_RESET, im_RESET, dm_RESET} = 4'b1111;
        reg_ifid_exmem_ENABLE = 1'b1;
        reg_exmem_wb_ENABLE   = 1'b1;
        im_WE   = 1'b0;
        im_DATA = 32'd0;
        {im_read_file, im_write_file, dm_read_file, dm_write_file} = 4'b0000;
        test_reset();
        test_basic();
        test_back_to_back();
        test_jump();
        test_overflow();
        test_carry_borrow();
        test_freeze();
        test_rb_tf_reset();
        test_im_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
